// File: rtl/branch_resolver_if.sv
// branch_resolver_if: decode-side operand/instruction inputs and the fetch redirect handshake.
interface branch_resolver_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            opnd_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            fetch_resume;
  logic            taken;
  logic            misalign_err;
  logic            busy;
  modport master (
    output id_valid, id_instr, id_pc, rs1_data, rs2_data, opnd_valid, redirect_ready,
    input  redirect_valid, redirect_pc, fetch_resume, taken, misalign_err, busy
  );
  modport slave (
    input  id_valid, id_instr, id_pc, rs1_data, rs2_data, opnd_valid, redirect_ready,
    output redirect_valid, redirect_pc, fetch_resume, taken, misalign_err, busy
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: resolves B-type/JAL (and JALR under BRANCH_RESOLVER_JALR_EN) for a stalled front end.
module branch_resolver #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst_n,
  branch_resolver_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, REDIRECT = 2'd2, RESUME = 2'd3;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  logic [1:0]      state;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc, rpc_q, b_imm, j_imm, jump_tgt, pc4;
  logic            taken_q, mis_q, is_br, is_jal, is_jalr, cap_cf, eq, lt, ltu, br_take, take, mis, resolve;
  logic [2:0]      f3;
  assign f3 = instr[14:12];
  assign is_br = instr[6:0] == OP_BR;
  assign is_jal = instr[6:0] == OP_JAL;
  assign b_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc4 = pc + XLEN'(4);
`ifdef BRANCH_RESOLVER_JALR_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
  logic [XLEN-1:0] jalr_sum;
  assign is_jalr = instr[6:0] == OP_JALR;
  assign jalr_sum = bus.rs1_data + {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign jump_tgt = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + (is_jal ? j_imm : b_imm);
  assign cap_cf = bus.id_instr[6:0] == OP_BR || bus.id_instr[6:0] == OP_JAL || bus.id_instr[6:0] == OP_JALR;
`else
  assign is_jalr = 1'b0;
  assign jump_tgt = pc + (is_jal ? j_imm : b_imm);
  assign cap_cf = bus.id_instr[6:0] == OP_BR || bus.id_instr[6:0] == OP_JAL;
`endif
  assign eq = bus.rs1_data == bus.rs2_data;
  assign lt = $signed(bus.rs1_data) < $signed(bus.rs2_data);
  assign ltu = bus.rs1_data < bus.rs2_data;
  // funct3[0] inverts the base test; 010/011 fall into the never-taken slot
  assign br_take = f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (!f3[1] && (eq ^ f3[0]));
  assign take = is_jal || is_jalr || (is_br && br_take);
  assign mis = take && jump_tgt[1];
  assign resolve = is_jal || bus.opnd_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      instr <= '0;
      pc <= '0;
      rpc_q <= '0;
      taken_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (state == IDLE && bus.id_valid && cap_cf) begin
        instr <= bus.id_instr;
        pc <= bus.id_pc;
        state <= EVAL;
      end
      if (state == EVAL && resolve) begin
        rpc_q <= (take && !mis) ? jump_tgt : pc4;
        taken_q <= take && !mis;
        mis_q <= mis;
        state <= REDIRECT;
      end
      if (state == REDIRECT && bus.redirect_ready) state <= RESUME;
      if (state == RESUME) state <= IDLE;
    end
  end
  assign bus.redirect_valid = state == REDIRECT;
  assign bus.fetch_resume = state == RESUME;
  assign bus.busy = state != IDLE;
  assign bus.redirect_pc = rpc_q;
  assign bus.taken = taken_q;
  assign bus.misalign_err = mis_q;
endmodule
